// File: rtl/clock_pkg.sv
// clock_pkg: shared time-of-day widths, limits and alarm state encoding
package clock_pkg;
    localparam int HOUR_W        = 5;
    localparam int MIN_W         = 6;
    localparam int SEC_W         = 6;
    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} alarm_state_t;
endpackage

// File: rtl/time_add_minutes.sv
// time_add_minutes: combinational hour:minute plus a constant minute offset, wrapping at midnight
module time_add_minutes import clock_pkg::*; #(
    parameter int ADD_MIN = 5
) (
    input  logic [HOUR_W-1:0] hour_in,
    input  logic [MIN_W-1:0]  min_in,
    output logic [HOUR_W-1:0] hour_out,
    output logic [MIN_W-1:0]  min_out
);
    logic [MIN_W:0] sum;
    logic           carry;

    // one extra bit holds minute sums up to 59+59 before folding back into 0..59
    always_comb begin
        sum      = {1'b0, min_in} + (MIN_W+1)'(ADD_MIN);
        carry    = sum >= (MIN_W+1)'(MIN_PER_HOUR);
        min_out  = carry ? MIN_W'(sum - (MIN_W+1)'(MIN_PER_HOUR)) : sum[MIN_W-1:0];
        hour_out = !carry ? hour_in :
                   (hour_in == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : hour_in + 1'b1;
    end
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: programmable HH:MM alarm with snooze, ring timeout and disarm
module alarm_controller import clock_pkg::*; #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HOUR_W-1:0] hour,
    input  logic [MIN_W-1:0]  minute,
    input  logic [SEC_W-1:0]  second,
    input  logic              set_en,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_minute,
    input  logic              arm,
    input  logic              disarm,
    input  logic              snooze,
    output logic              ring,
    output logic              armed,
    output logic              snoozing,
    output logic              set_err,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_minute
);
    localparam logic [7:0] RING_LIM = 8'(RING_SECONDS);
    localparam logic [2:0] SNZ_LIM  = 3'(MAX_SNOOZE);

    alarm_state_t      state_q, state_d;
    logic [HOUR_W-1:0] alarm_h_q, alarm_h_d, tgt_h_q, tgt_h_d, snz_h;
    logic [MIN_W-1:0]  alarm_m_q, alarm_m_d, tgt_m_q, tgt_m_d, snz_m;
    logic [SEC_W-1:0]  second_q;
    logic [7:0]        ring_cnt_q, ring_cnt_d;
    logic [2:0]        snooze_cnt_q, snooze_cnt_d;
    logic              ring_q, ring_d, armed_q, armed_d, snoozing_q, snoozing_d;
    logic              set_err_q, set_err_d;
    logic              tick, fire, set_ok;

    time_add_minutes #(.ADD_MIN(SNOOZE_MINUTES)) u_snooze_add (
        .hour_in  (hour),
        .min_in   (minute),
        .hour_out (snz_h),
        .min_out  (snz_m)
    );

    // the day counter can be paused, so a second only counts when its value changes
    assign tick   = second != second_q;
    assign fire   = tick && (second == '0) && (hour == tgt_h_q) && (minute == tgt_m_q);
    assign set_ok = (set_hour < HOUR_W'(HOURS_PER_DAY)) && (set_minute < MIN_W'(MIN_PER_HOUR));

    // next state: one command per cycle, disarm > set_en > snooze > arm > fire/tick
    always_comb begin
        state_d      = state_q;
        alarm_h_d    = alarm_h_q;
        alarm_m_d    = alarm_m_q;
        tgt_h_d      = tgt_h_q;
        tgt_m_d      = tgt_m_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        set_err_d    = 1'b0;
        if (disarm) begin
            state_d = IDLE;
            tgt_h_d = alarm_h_q;
            tgt_m_d = alarm_m_q;
        end else if (set_en) begin
            if (set_ok) begin
                alarm_h_d = set_hour;
                alarm_m_d = set_minute;
                tgt_h_d   = set_hour;
                tgt_m_d   = set_minute;
                state_d   = (state_q == RINGING || state_q == SNOOZE) ? ARMED : state_q;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (snooze && state_q == RINGING && snooze_cnt_q < SNZ_LIM) begin
            state_d      = SNOOZE;
            tgt_h_d      = snz_h;
            tgt_m_d      = snz_m;
            snooze_cnt_d = snooze_cnt_q + 3'd1;
        end else if (arm && state_q == IDLE) begin
            state_d      = ARMED;
            tgt_h_d      = alarm_h_q;
            tgt_m_d      = alarm_m_q;
            snooze_cnt_d = '0;
        end else if ((state_q == ARMED || state_q == SNOOZE) && fire) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
        end else if (state_q == RINGING && tick) begin
            ring_cnt_d = ring_cnt_q + 8'd1;
            if (ring_cnt_q + 8'd1 == RING_LIM) begin
                state_d      = ARMED;
                tgt_h_d      = alarm_h_q;
                tgt_m_d      = alarm_m_q;
                snooze_cnt_d = '0;
            end
        end
        ring_d     = state_d == RINGING;
        armed_d    = state_d != IDLE;
        snoozing_d = state_d == SNOOZE;
    end

    // state, counters and registered outputs; reset silences the buzzer without waiting for clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            alarm_h_q    <= '0;
            alarm_m_q    <= '0;
            tgt_h_q      <= '0;
            tgt_m_q      <= '0;
            second_q     <= '0;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            ring_q       <= 1'b0;
            armed_q      <= 1'b0;
            snoozing_q   <= 1'b0;
            set_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_h_q    <= alarm_h_d;
            alarm_m_q    <= alarm_m_d;
            tgt_h_q      <= tgt_h_d;
            tgt_m_q      <= tgt_m_d;
            second_q     <= second;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            ring_q       <= ring_d;
            armed_q      <= armed_d;
            snoozing_q   <= snoozing_d;
            set_err_q    <= set_err_d;
        end
    end

    assign ring         = ring_q;
    assign armed        = armed_q;
    assign snoozing     = snoozing_q;
    assign set_err      = set_err_q;
    assign alarm_hour   = alarm_h_q;
    assign alarm_minute = alarm_m_q;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: scoreboard bench driving directed and random clock/strobe traffic against a minutes-of-day model
module tb_alarm_controller;
    localparam int RING_SECONDS   = 60;
    localparam int SNOOZE_MINUTES = 5;
    localparam int MAX_SNOOZE     = 3;
    localparam int OFF = 0, ON = 1, RING = 2, NAP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] hour, set_hour, alarm_hour;
    logic [5:0] minute, second, set_minute, alarm_minute;
    logic       set_en, arm, disarm, snooze;
    logic       ring, armed, snoozing, set_err;

    alarm_controller #(
        .RING_SECONDS   (RING_SECONDS),
        .SNOOZE_MINUTES (SNOOZE_MINUTES),
        .MAX_SNOOZE     (MAX_SNOOZE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hour         (hour),
        .minute       (minute),
        .second       (second),
        .set_en       (set_en),
        .set_hour     (set_hour),
        .set_minute   (set_minute),
        .arm          (arm),
        .disarm       (disarm),
        .snooze       (snooze),
        .ring         (ring),
        .armed        (armed),
        .snoozing     (snoozing),
        .set_err      (set_err),
        .alarm_hour   (alarm_hour),
        .alarm_minute (alarm_minute)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [14:0] exp_q[$];

    // reference model: times kept as minutes since midnight, ring time as a countdown of ticks
    int m_mode, m_alarm, m_tgt, m_left, m_snz, m_prev;
    bit m_err;

    int cur_h, cur_m, cur_s, s_sh, s_sm;
    bit s_set, s_arm, s_dis, s_snz;

    task automatic model_reset();
        m_mode = OFF; m_alarm = 0; m_tgt = 0; m_left = 0; m_snz = 0; m_prev = 0; m_err = 0;
    endtask

    task automatic model_step(input int h, input int m, input int s, input bit se, input int sh,
                              input int sm, input bit ar, input bit dis, input bit snz);
        bit tick, fire;
        int now;
        tick   = (s != m_prev);
        m_prev = s;
        now    = h * 60 + m;
        fire   = tick && s == 0 && now == m_tgt;
        m_err  = 0;
        if (dis) begin
            m_mode = OFF;
            m_tgt  = m_alarm;
        end else if (se) begin
            if (sh < 24 && sm < 60) begin
                m_alarm = sh * 60 + sm;
                m_tgt   = m_alarm;
                if (m_mode == RING || m_mode == NAP) m_mode = ON;
            end else m_err = 1;
        end else if (snz && m_mode == RING && m_snz < MAX_SNOOZE) begin
            m_mode = NAP;
            m_tgt  = (now + SNOOZE_MINUTES) % 1440;
            m_snz++;
        end else if (ar && m_mode == OFF) begin
            m_mode = ON;
            m_tgt  = m_alarm;
            m_snz  = 0;
        end else if ((m_mode == ON || m_mode == NAP) && fire) begin
            m_mode = RING;
            m_left = RING_SECONDS;
        end else if (m_mode == RING && tick) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = ON;
                m_tgt  = m_alarm;
                m_snz  = 0;
            end
        end
    endtask

    function automatic logic [14:0] model_out();
        return {m_mode == RING, m_mode != OFF, m_mode == NAP, m_err, 5'(m_alarm / 60), 6'(m_alarm % 60)};
    endfunction

    // monitor: compare the outputs produced by each clock edge against the queued prediction
    always @(posedge clk) begin
        logic [14:0] e, a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {ring, armed, snoozing, set_err, alarm_hour, alarm_minute};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t got=%h exp=%h (ring,armed,snoozing,set_err,hh,mm)", $time, a, e);
            end
        end
    end

    task automatic cyc1();
        hour = 5'(cur_h); minute = 6'(cur_m); second = 6'(cur_s);
        set_en = s_set; set_hour = 5'(s_sh); set_minute = 6'(s_sm);
        arm = s_arm; disarm = s_dis; snooze = s_snz;
        model_step(cur_h, cur_m, cur_s, s_set, s_sh, s_sm, s_arm, s_dis, s_snz);
        exp_q.push_back(model_out());
        @(negedge clk);
        s_set = 0; s_arm = 0; s_dis = 0; s_snz = 0;
    endtask

    task automatic adv();
        cur_s++;
        if (cur_s == 60) begin
            cur_s = 0; cur_m++;
            if (cur_m == 60) begin
                cur_m = 0; cur_h = (cur_h + 1) % 24;
            end
        end
    endtask

    task automatic sec_step(input int n);
        repeat (n) begin
            adv(); cyc1(); cyc1();
        end
    endtask

    task automatic go(input int h, input int m, input int s);
        cur_h = h; cur_m = m; cur_s = s; cyc1();
    endtask

    task automatic set_alarm(input int h, input int m);
        s_set = 1; s_sh = h; s_sm = m; cyc1();
    endtask

    task automatic check_zero(input string name);
        logic [14:0] a;
        a = {ring, armed, snoozing, set_err, alarm_hour, alarm_minute};
        n_chk++;
        if (a !== 15'h0) begin
            n_fail++;
            $display("FAIL %s got=%h exp=0000", name, a);
        end
    endtask

    // reset asserted mid-cycle: outputs must clear before any clock edge arrives
    task automatic do_reset();
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int t;
        reset = 1'b0;
        {set_en, arm, disarm, snooze} = '0;
        hour = '0; minute = '0; second = '0; set_hour = '0; set_minute = '0;
        {s_set, s_arm, s_dis, s_snz} = '0;
        s_sh = 0; s_sm = 0;
        model_reset();
        #3 check_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        go(7, 29, 50);
        set_alarm(7, 30);
        s_arm = 1; cyc1();
        go(7, 29, 58); cyc1();
        sec_step(70);

        set_alarm(23, 58);
        go(23, 57, 58);
        sec_step(12);
        s_snz = 1; cyc1();
        cyc1();
        go(0, 2, 58);
        sec_step(4);
        s_snz = 1; cyc1();
        go(0, 7, 58);
        sec_step(4);
        s_snz = 1; cyc1();
        go(0, 12, 58);
        sec_step(4);
        s_snz = 1; cyc1();
        sec_step(5);

        set_alarm(24, 0);
        cyc1();
        set_alarm(10, 60);
        cyc1();

        s_dis = 1; cyc1();
        set_alarm(6, 0);
        s_arm = 1; cyc1();
        go(5, 59, 58);
        sec_step(2);
        repeat (20) cyc1();
        sec_step(3);
        s_dis = 1; cyc1();
        cyc1();

        set_alarm(12, 0);
        s_arm = 1; cyc1();
        go(11, 59, 59);
        sec_step(3);
        do_reset();
        go(11, 59, 59);
        cyc1();

        for (int i = 0; i < 5000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 25) adv();
            else if (r == 25) begin
                t = (m_tgt + 1439) % 1440;
                cur_h = t / 60; cur_m = t % 60; cur_s = $urandom_range(55, 59);
            end else if (r == 26) begin
                cur_h = $urandom_range(0, 23); cur_m = $urandom_range(0, 59); cur_s = $urandom_range(0, 59);
            end
            s_set = ($urandom_range(0, 59) == 0);
            s_sh  = $urandom_range(0, 25);
            s_sm  = $urandom_range(0, 61);
            s_arm = ($urandom_range(0, 19) == 0);
            s_dis = ($urandom_range(0, 149) == 0);
            s_snz = ($urandom_range(0, 14) == 0);
            if (i == 2500) do_reset();
            cyc1();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
